// File: rtl/serial_alu_seq.sv
// -----------------------------------------------------------------------------
// serial_alu_seq
//
// Bit-serial sequencer for an external one-bit ALU. On an accepted start the
// operands and opcode are latched and fed to the ALU one bit per cycle, LSB
// first. The returned result bit is written into the result register, and the
// carry is chained through a local carry register for additions. The opcode
// 3 is illegal: it finishes in one cycle with err set and the ALU never runs.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        request to begin an operation, honoured only in IDLE
//   op[1:0]      0 = add, 1 = and, 2 = not(a), 3 = illegal
//   a, b         WIDTH-bit operands
//   busy         high while bits are being processed (RUN)
//   done         one-cycle completion pulse (DONE)
//   result       final result, held until the next accepted start
//   carry_out    final carry of an add, 0 for other ops
//   err          set with done for the illegal opcode, held like result
//   alu_a/alu_b  current operand bits to the one-bit ALU (0 outside RUN)
//   alu_c_in     carry into the one-bit ALU (0 outside RUN)
//   alu_op       latched opcode to the one-bit ALU
//   alu_result   one-bit ALU result, combinational from the alu_* outputs
//   alu_c_out    one-bit ALU carry, valid only for add (may float otherwise)
// -----------------------------------------------------------------------------
module serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             err,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_c_in,
    output logic [1:0]       alu_op,
    input  logic             alu_result,
    input  logic             alu_c_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] OP_ADD     = 2'd0;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [1:0]       op_q,        op_d;
    logic             carry_q,     carry_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             carry_out_q, carry_out_d;
    logic             err_q,       err_d;

    // -------------------------------------------------------------------------
    // State register. Reset wins over everything, including a run in flight,
    // so an aborted operation never reaches DONE.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_ADD;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            err_q       <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath update.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a hold-value default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        err_d       = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d         = a;
                    b_d         = b;
                    op_d        = op;
                    carry_d     = 1'b0;
                    cnt_d       = '0;
                    result_d    = '0;
                    carry_out_d = 1'b0;
                    err_d       = (op == OP_ILLEGAL);
                    state_d     = (op == OP_ILLEGAL) ? S_DONE : S_RUN;
                end
            end

            S_RUN: begin
                result_d[cnt_q] = alu_result;
                // alu_c_out only carries meaning for add; for other ops it may
                // float, so it is kept off the carry path entirely.
                carry_d = (op_q == OP_ADD) ? alu_c_out : 1'b0;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    carry_out_d = carry_d;
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs. busy and done decode distinct states, so they never overlap.
    // -------------------------------------------------------------------------
    always_comb begin
        busy      = (state_q == S_RUN);
        done      = (state_q == S_DONE);
        result    = result_q;
        carry_out = carry_out_q;
        err       = err_q;
        alu_op    = op_q;
        alu_a     = 1'b0;
        alu_b     = 1'b0;
        alu_c_in  = 1'b0;
        if (state_q == S_RUN) begin
            alu_a    = a_q[cnt_q];
            alu_b    = b_q[cnt_q];
            alu_c_in = carry_q;
        end
    end

endmodule
